audio_mix_sched: RTL and testbench

Time-multiplexed stereo mixer and sample scheduler that feeds the `left_in`/`right_in` inputs of the I2S audio output path. It generates the 48/96 kHz sample tick and snapshots NCH signed 16-bit sources (beeper, AY channels, covox, etc.) on each tick. One shared multiply-accumulate unit then walks the channels with per-channel volume and pan, and the block emits a saturated stereo sample with a one-cycle valid strobe.

---
 rtl/audio_pkg.sv | 19 +
 rtl/audio_tick_gen.sv | 40 ++++
 rtl/audio_mix_sched.sv | 149 ++++++++++++++
 tb/tb_audio_mix_sched.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared constants and FSM encoding for the audio mixer/scheduler path.
package audio_pkg;

    localparam int AUDIO_RATE_48K = 48000;
    localparam int AUDIO_RATE_96K = 96000;
    localparam int AUDIO_DW       = 16;
    localparam int VOL_W          = 4;
    localparam int VOL_SHIFT      = 4;
    // Signed sample times zero-extended volume: 16 + (4 + 1) bits.
    localparam int PROD_W         = AUDIO_DW + VOL_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_MAC   = 2'd2,
        ST_SAT   = 2'd3
    } mix_state_e;

endpackage

// File: rtl/audio_tick_gen.sv
// Fractional phase-accumulator tick for 48/96 kHz sample scheduling.
// Also usable as a clock-enable source for the I2S master clock.
module audio_tick_gen
    import audio_pkg::*;
#(
    parameter int unsigned CLK_RATE = 50000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_rate,
    output logic tick
);

    logic [31:0] cnt_q, cnt_d;
    logic [31:0] sum;
    logic        tick_q, tick_d;

    always_comb begin
        sum    = cnt_q + (sample_rate ? 32'(AUDIO_RATE_96K) : 32'(AUDIO_RATE_48K));
        cnt_d  = sum;
        tick_d = 1'b0;
        if (sum >= 32'(CLK_RATE)) begin
            cnt_d  = sum - 32'(CLK_RATE);
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/audio_mix_sched.sv
// Time-multiplexed stereo mixer: snapshots NCH sources on each sample tick,
// walks them through one shared MAC with volume/pan, emits a saturated pair.
module audio_mix_sched
    import audio_pkg::*;
#(
    parameter int unsigned CLK_RATE = 50000000,
    parameter int          NCH      = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sample_rate,
    input  logic [AUDIO_DW*NCH-1:0]    ch_data,
    input  logic [VOL_W*NCH-1:0]       ch_vol,
    input  logic [2*NCH-1:0]           ch_pan,
    output logic signed [AUDIO_DW-1:0] left_out,
    output logic signed [AUDIO_DW-1:0] right_out,
    output logic                       sample_valid,
    output logic                       busy,
    output logic                       overrun
);

    localparam int IDX_W = $clog2(NCH);
    localparam int ACC_W = PROD_W + IDX_W;
    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(NCH - 1);
    localparam logic signed [ACC_W-1:0] OUT_MAX  = ACC_W'((1 << (AUDIO_DW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] OUT_MIN  = ACC_W'(-(1 << (AUDIO_DW - 1)));

    // Floor shift (arithmetic) followed by clamp to the 16-bit output range.
    function automatic logic signed [AUDIO_DW-1:0] sat_out(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] shifted;
        logic signed [ACC_W-1:0] clamped;
        shifted = acc >>> VOL_SHIFT;
        clamped = shifted;
        if (shifted > OUT_MAX) clamped = OUT_MAX;
        else if (shifted < OUT_MIN) clamped = OUT_MIN;
        return clamped[AUDIO_DW-1:0];
    endfunction

    logic tick;

    audio_tick_gen #(.CLK_RATE(CLK_RATE)) u_tick_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_rate (sample_rate),
        .tick        (tick)
    );

    mix_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           ch_idx_q, ch_idx_d;
    logic                       ovr_q, ovr_d;
    logic                       vld_q, vld_d;
    logic signed [AUDIO_DW-1:0] left_q, left_d;
    logic signed [AUDIO_DW-1:0] right_q, right_d;
    logic signed [ACC_W-1:0]    acc_l_q, acc_l_d;
    logic signed [ACC_W-1:0]    acc_r_q, acc_r_d;
    logic                       latch_en;

    logic signed [AUDIO_DW-1:0] data_q [NCH];
    logic [VOL_W-1:0]           vol_q  [NCH];
    logic [1:0]                 pan_q  [NCH];

    logic signed [AUDIO_DW-1:0] cur_data;
    logic signed [VOL_W:0]      cur_vol;
    logic [1:0]                 cur_pan;
    logic signed [PROD_W-1:0]   prod;

    // The single shared multiplier, fed from the shadow copy of the current channel.
    assign cur_data = data_q[ch_idx_q];
    assign cur_vol  = signed'({1'b0, vol_q[ch_idx_q]});
    assign cur_pan  = pan_q[ch_idx_q];
    assign prod     = PROD_W'(cur_data) * PROD_W'(cur_vol);

    always_comb begin
        state_d  = state_q;
        ch_idx_d = ch_idx_q;
        acc_l_d  = acc_l_q;
        acc_r_d  = acc_r_q;
        left_d   = left_q;
        right_d  = right_q;
        vld_d    = 1'b0;
        latch_en = 1'b0;
        // Ticks are only accepted in IDLE; anything else is lost and flagged.
        ovr_d    = ovr_q | (tick && (state_q != ST_IDLE));

        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                latch_en = 1'b1;
                acc_l_d  = '0;
                acc_r_d  = '0;
                ch_idx_d = '0;
                state_d  = ST_MAC;
            end
            ST_MAC: begin
                if (cur_pan[0]) acc_l_d = acc_l_q + ACC_W'(prod);
                if (cur_pan[1]) acc_r_d = acc_r_q + ACC_W'(prod);
                if (ch_idx_q == LAST_IDX) state_d = ST_SAT;
                else ch_idx_d = ch_idx_q + IDX_W'(1);
            end
            ST_SAT: begin
                left_d  = sat_out(acc_l_q);
                right_d = sat_out(acc_r_q);
                vld_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ch_idx_q <= '0;
            ovr_q    <= 1'b0;
            vld_q    <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
        end else begin
            state_q  <= state_d;
            ch_idx_q <= ch_idx_d;
            ovr_q    <= ovr_d;
            vld_q    <= vld_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    // Datapath registers carry no reset; they are always written before use.
    always_ff @(posedge clk) begin
        if (latch_en) begin
            for (int i = 0; i < NCH; i++) begin
                data_q[i] <= ch_data[AUDIO_DW*i +: AUDIO_DW];
                vol_q[i]  <= ch_vol[VOL_W*i +: VOL_W];
                pan_q[i]  <= ch_pan[2*i +: 2];
            end
        end
        acc_l_q <= acc_l_d;
        acc_r_q <= acc_r_d;
    end

    assign left_out     = left_q;
    assign right_out    = right_q;
    assign sample_valid = vld_q;
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_audio_mix_sched.sv
// Bench for audio_mix_sched: a fast-tick instance checked cycle by cycle
// against a behavioural model, and a 50 MHz instance checked for tick counts.
module tb_audio_mix_sched;

    localparam int          NCH       = 4;
    localparam int unsigned FAST_RATE = 480000;
    localparam int unsigned STD_RATE  = 50000000;

    logic                clk         = 1'b0;
    logic                reset_n     = 1'b0;
    logic                sample_rate = 1'b0;
    logic [16*NCH-1:0]   ch_data     = '0;
    logic [4*NCH-1:0]    ch_vol      = '0;
    logic [2*NCH-1:0]    ch_pan      = '0;

    logic signed [15:0]  f_left, f_right, s_left, s_right;
    logic                f_vld, f_busy, f_ovr, s_vld, s_busy, s_ovr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    audio_mix_sched #(.CLK_RATE(FAST_RATE), .NCH(NCH)) u_fast (
        .clk(clk), .reset_n(reset_n), .sample_rate(sample_rate),
        .ch_data(ch_data), .ch_vol(ch_vol), .ch_pan(ch_pan),
        .left_out(f_left), .right_out(f_right), .sample_valid(f_vld),
        .busy(f_busy), .overrun(f_ovr)
    );

    audio_mix_sched #(.CLK_RATE(STD_RATE), .NCH(NCH)) u_std (
        .clk(clk), .reset_n(reset_n), .sample_rate(sample_rate),
        .ch_data(ch_data), .ch_vol(ch_vol), .ch_pan(ch_pan),
        .left_out(s_left), .right_out(s_right), .sample_valid(s_vld),
        .busy(s_busy), .overrun(s_ovr)
    );

    task automatic check(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Mix rule from first principles: sum, floor-divide by 16, clamp.
    function automatic logic signed [15:0] mix_ref(input int s);
        int q;
        q = (s >= 0) ? s / 16 : -((-s + 15) / 16);
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return 16'(q);
    endfunction

    // ---------------- behavioural model of u_fast ----------------
    longint             m_tot;
    int                 m_cyc, m_lat;
    bit                 m_act, m_ovr, m_live, m_prev_rate;
    logic signed [15:0] m_left, m_right, m_res_l, m_res_r;

    always @(posedge clk) m_live = reset_n;

    always @(negedge clk) begin
        bit     tk, exp_busy, exp_vld;
        longint old_k;
        int     sl, sr, p;
        tk = 1'b0;
        if (!reset_n) begin
            m_tot = 0; m_cyc = 0; m_lat = 0; m_act = 0; m_ovr = 0;
            m_left = '0; m_right = '0;
            check("rst left", f_left, 0);
            check("rst right", f_right, 0);
            check("rst valid", f_vld, 0);
            check("rst busy", f_busy, 0);
            check("rst overrun", f_ovr, 0);
        end else begin
            if (m_live) begin
                m_cyc++;
                old_k = m_tot / FAST_RATE;
                m_tot += m_prev_rate ? 96000 : 48000;
                tk = (m_tot / FAST_RATE) != old_k;
            end
            exp_busy = m_act && (m_cyc >= m_lat) && (m_cyc <= m_lat + NCH + 1);
            exp_vld  = m_act && (m_cyc == m_lat + NCH + 2);
            if (exp_vld) begin
                m_left  = m_res_l;
                m_right = m_res_r;
            end
            check("model left", f_left, m_left);
            check("model right", f_right, m_right);
            check("model valid", f_vld, exp_vld);
            check("model busy", f_busy, exp_busy);
            check("model overrun", f_ovr, m_ovr);
            if (m_act && m_cyc == m_lat) begin
                sl = 0; sr = 0;
                for (int i = 0; i < NCH; i++) begin
                    p = int'($signed(ch_data[16*i +: 16])) * int'(ch_vol[4*i +: 4]);
                    if (ch_pan[2*i])     sl += p;
                    if (ch_pan[2*i + 1]) sr += p;
                end
                m_res_l = mix_ref(sl);
                m_res_r = mix_ref(sr);
            end
            if (tk) begin
                if (exp_busy) m_ovr = 1'b1;
                else begin
                    m_act = 1'b1;
                    m_lat = m_cyc + 1;
                end
            end
        end
        m_prev_rate = sample_rate;
    end

    // ---------------- pulse counter for u_std ----------------
    int s_cnt      = 0;
    bit s_count_en = 1'b0;
    always @(negedge clk) if (s_count_en && s_vld === 1'b1) s_cnt++;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int i, input logic [15:0] d, input logic [3:0] v, input logic [1:0] pn);
        ch_data[16*i +: 16] = d;
        ch_vol[4*i +: 4]    = v;
        ch_pan[2*i +: 2]    = pn;
    endtask

    task automatic wait_fast_vld(input int limit, output int cycles);
        cycles = 0;
        while (f_vld !== 1'b1 && cycles < limit) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("fast valid seen", f_vld, 1);
    endtask

    task automatic wait_busy(input bit want, input int limit);
        int n;
        n = 0;
        while (f_busy !== want && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        check("busy level reached", f_busy, want);
    endtask

    initial begin
        int n;

        // Reset state, with a single-channel left-only source prepared.
        set_ch(0, 16'h1000, 4'd8, 2'b01);
        step(3);
        check("reset left", f_left, 0);
        check("reset right", f_right, 0);
        check("reset valid", f_vld, 0);
        check("reset busy", f_busy, 0);
        check("reset overrun", f_ovr, 0);

        // First tick 10 cycles after release, valid NCH+3 later.
        reset_n = 1'b1;
        wait_fast_vld(40, n);
        check("first valid cycle", n, 17);
        check("ch0 vol8 left", f_left, 16'sh0800);
        check("ch0 vol8 right", f_right, 16'sh0000);

        for (int i = 0; i < NCH; i++) set_ch(i, 16'h7FFF, 4'd15, 2'b11);
        step(1);
        wait_fast_vld(20, n); step(1);
        wait_fast_vld(20, n);
        check("pos sat left", f_left, 16'sh7FFF);
        check("pos sat right", f_right, 16'sh7FFF);

        for (int i = 0; i < NCH; i++) set_ch(i, 16'h8000, 4'd15, 2'b11);
        step(1);
        wait_fast_vld(20, n); step(1);
        wait_fast_vld(20, n);
        check("neg sat left", f_left, 16'sh8000);
        check("neg sat right", f_right, 16'sh8000);

        for (int i = 0; i < NCH; i++) set_ch(i, 16'h0000, 4'd0, 2'b00);
        set_ch(0, 16'hFFFF, 4'd1, 2'b10);
        step(1);
        wait_fast_vld(20, n); step(1);
        wait_fast_vld(20, n);
        check("floor left", f_left, 16'sh0000);
        check("floor right", f_right, 16'shFFFF);

        // Inputs scrambled every cycle after LATCH must not disturb the sample.
        set_ch(0, 16'h1000, 4'd8, 2'b01);
        set_ch(1, 16'h0400, 4'd4, 2'b11);
        set_ch(2, 16'h0000, 4'd0, 2'b00);
        set_ch(3, 16'h0000, 4'd0, 2'b00);
        wait_busy(1'b0, 20);
        wait_busy(1'b1, 20);
        step(1);
        n = 0;
        while (f_vld !== 1'b1 && n < 20) begin
            ch_data = {$urandom(), $urandom()};
            ch_vol  = 16'($urandom());
            ch_pan  = 8'($urandom());
            step(1);
            n++;
        end
        check("scramble valid", f_vld, 1);
        check("scramble left", f_left, 16'sh0900);
        check("scramble right", f_right, 16'sh0100);

        // Random traffic, checked by the model every cycle.
        for (int k = 0; k < 300; k++) begin
            ch_data = {$urandom(), $urandom()};
            ch_vol  = 16'($urandom());
            ch_pan  = 8'($urandom());
            step(1);
        end

        // 96 kHz on the fast instance ticks every 5 cycles: overrun.
        for (int i = 0; i < NCH; i++) set_ch(i, 16'h0000, 4'd0, 2'b00);
        set_ch(0, 16'h1000, 4'd8, 2'b11);
        sample_rate = 1'b1;
        step(30);
        check("overrun sticky", f_ovr, 1);
        wait_fast_vld(20, n);
        check("pre-abort left", f_left, 16'sh0800);
        wait_busy(1'b1, 20);
        step(1);
        reset_n = 1'b0;
        #1;
        check("abort left", f_left, 0);
        check("abort right", f_right, 0);
        check("abort valid", f_vld, 0);
        check("abort busy", f_busy, 0);
        check("abort overrun", f_ovr, 0);
        sample_rate = 1'b0;
        step(2);
        reset_n = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step(1);
            check("no valid after abort", f_vld, 0);
        end

        // 50 MHz instance: 15000 cycles at 48 kHz, then at 96 kHz.
        reset_n = 1'b0;
        step(2);
        s_cnt = 0; s_count_en = 1'b1;
        reset_n = 1'b1;
        step(15000);
        s_count_en = 1'b0;
        check("48k pulse count", s_cnt, 14);
        check("48k overrun", s_ovr, 0);
        check("48k idle", s_busy, 0);
        check("48k left", s_left, 16'sh0800);
        check("48k right", s_right, 16'sh0800);

        reset_n = 1'b0;
        sample_rate = 1'b1;
        set_ch(0, 16'h1000, 4'd8, 2'b01);
        step(2);
        s_cnt = 0; s_count_en = 1'b1;
        reset_n = 1'b1;
        step(15000);
        s_count_en = 1'b0;
        check("96k pulse count", s_cnt, 28);
        check("96k overrun", s_ovr, 0);
        check("96k idle", s_busy, 0);
        check("96k left", s_left, 16'sh0800);
        check("96k right", s_right, 16'sh0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
